// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB/HALT)
// with req/ready handshakes to separate instruction and data memories.
module cpu_multicycle #(
  parameter int unsigned PC_WIDTH  = 16,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [PC_WIDTH-1:0] dmem_addr,
  output logic [31:0]         dmem_wdata,
  input  logic                dmem_ready,
  input  logic [31:0]         dmem_rdata,
  output logic                retire,
  output logic                halted
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnSrl  = 6'b000010;
  localparam logic [5:0] FnSra  = 6'b000011;
  localparam logic [5:0] FnJr   = 6'b001000;
  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnXor  = 6'b100110;
  localparam logic [5:0] FnNor  = 6'b100111;
  localparam logic [5:0] FnSlt  = 6'b101010;

  state_e              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] npc_q;
  logic [31:0]         ir_q;
  logic [31:0]         a_q;
  logic [31:0]         b_q;
  logic [31:0]         res_q;
  logic                rst_q;   // high for the one cycle after a sampled reset
  logic [31:0]         gr [32];

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt, dest;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] imm_s, imm_z;
  logic        is_sw;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign imm    = ir_q[15:0];
  assign imm_s  = {{16{imm[15]}}, imm};
  assign imm_z  = {16'h0, imm};
  assign is_sw  = (opcode == OpSw);
  assign dest   = (opcode == OpRtype) ? rd : rt;

  logic [PC_WIDTH-1:0] pc4, br_tgt, j_tgt;
  assign pc4    = pc_q + PC_WIDTH'(4);
  assign br_tgt = pc4 + PC_WIDTH'(imm_s << 2);
  // Upper PC bits above 27 come from PC+4 only when the PC is wide enough to have them.
  assign j_tgt  = PC_WIDTH'((32'(pc4) & 32'hF000_0000) | {4'h0, ir_q[25:0], 2'b00});

  logic [31:0]         alu_res;
  logic [PC_WIDTH-1:0] exec_npc;
  state_e              exec_to;
  logic                link;

  // EXEC datapath: ALU result, next PC and the state that follows EXEC.
  always_comb begin
    alu_res  = 32'h0;
    exec_npc = pc4;
    exec_to  = StFetch;
    link     = 1'b0;
    case (opcode)
      OpRtype: begin
        exec_to = StWb;
        case (funct)
          FnAdd, FnAddu: alu_res = a_q + b_q;
          FnSub, FnSubu: alu_res = a_q - b_q;
          FnAnd:         alu_res = a_q & b_q;
          FnOr:          alu_res = a_q | b_q;
          FnXor:         alu_res = a_q ^ b_q;
          FnNor:         alu_res = ~(a_q | b_q);
          FnSlt:         alu_res = {31'h0, $signed(a_q) < $signed(b_q)};
          FnSll:         alu_res = b_q << shamt;
          FnSrl:         alu_res = b_q >> shamt;
          FnSra:         alu_res = $signed(b_q) >>> shamt;
          FnJr: begin
            exec_to  = StFetch;
            exec_npc = a_q[PC_WIDTH-1:0];
          end
          default:       exec_to = StFetch;
        endcase
      end
      OpAddi, OpAddiu: begin alu_res = a_q + imm_s;                               exec_to = StWb; end
      OpSlti:          begin alu_res = {31'h0, $signed(a_q) < $signed(imm_s)};    exec_to = StWb; end
      OpAndi:          begin alu_res = a_q & imm_z;                               exec_to = StWb; end
      OpOri:           begin alu_res = a_q | imm_z;                               exec_to = StWb; end
      OpLui:           begin alu_res = {imm, 16'h0};                              exec_to = StWb; end
      OpLw, OpSw:      begin alu_res = a_q + imm_s;                               exec_to = StMem; end
      OpBeq:           if (a_q == b_q) exec_npc = br_tgt;
      OpBne:           if (a_q != b_q) exec_npc = br_tgt;
      OpJ:             exec_npc = j_tgt;
      OpJal: begin
        exec_npc = j_tgt;
        link     = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are forced low in the cycle following a sampled reset.
  always_comb begin
    imem_req   = !rst_q && (state_q == StFetch);
    imem_addr  = rst_q ? '0 : pc_q;
    dmem_req   = !rst_q && (state_q == StMem);
    dmem_we    = dmem_req && is_sw;
    dmem_addr  = dmem_req ? res_q[PC_WIDTH-1:0] : '0;
    dmem_wdata = dmem_we ? b_q : 32'h0;
    halted     = !rst_q && (state_q == StHalt);
    retire     = !rst_q && (((state_q == StExec) && (exec_to == StFetch)) ||
                            (dmem_req && dmem_ready && is_sw) ||
                            (state_q == StWb));
  end

  // FSM, architectural state and register file.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC[PC_WIDTH-1:0];
      npc_q   <= '0;
      ir_q    <= 32'h0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      res_q   <= 32'h0;
      rst_q   <= 1'b1;
      for (int i = 0; i < 32; i++) gr[i] <= 32'h0;
    end else begin
      rst_q <= 1'b0;
      case (state_q)
        StFetch: begin
          if (imem_req && imem_ready) begin
            ir_q    <= imem_rdata;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          if (ir_q == HALT_WORD) begin
            state_q <= StHalt;
          end else begin
            a_q     <= (rs == 5'd0) ? 32'h0 : gr[rs];
            b_q     <= (rt == 5'd0) ? 32'h0 : gr[rt];
            state_q <= StExec;
          end
        end
        StExec: begin
          res_q   <= alu_res;
          npc_q   <= exec_npc;
          state_q <= exec_to;
          if (exec_to == StFetch) pc_q <= exec_npc;
          if (link) gr[31] <= 32'(pc4);
        end
        StMem: begin
          if (dmem_ready) begin
            if (is_sw) begin
              // A store finishes here, so it commits its PC on the way out.
              pc_q    <= npc_q;
              state_q <= StFetch;
            end else begin
              res_q   <= dmem_rdata;
              state_q <= StWb;
            end
          end
        end
        StWb: begin
          if (dest != 5'd0) gr[dest] <= res_q;
          pc_q    <= npc_q;
          state_q <= StFetch;
        end
        StHalt: ;
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: directed programs with hand-computed results for cpu_multicycle.
module tb_cpu_multicycle;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  always #5 clock = ~clock;

  // Main core (PC_WIDTH 16) with wait-state memory model.
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted;
  logic [15:0] imem_addr, dmem_addr;
  logic [31:0] imem_rdata, dmem_wdata, dmem_rdata;

  cpu_multicycle dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .retire(retire), .halted(halted)
  );

  // Narrow core for PC wrap-around: beq at 0xFC, everything else is HALT.
  logic       n_imem_req, n_dmem_req, n_dmem_we, n_retire, n_halted;
  logic [7:0] n_imem_addr, n_dmem_addr;
  logic [31:0] n_imem_rdata, n_dmem_wdata;

  assign n_imem_rdata = (n_imem_addr == 8'hFC) ? 32'h1000_0001 : 32'hFFFF_FFFF;

  cpu_multicycle #(.PC_WIDTH(8), .RESET_PC(32'hFC), .HALT_WORD(32'hFFFF_FFFF)) dut_n (
    .clock(clock), .reset(reset),
    .imem_req(n_imem_req), .imem_addr(n_imem_addr), .imem_ready(n_imem_req),
    .imem_rdata(n_imem_rdata),
    .dmem_req(n_dmem_req), .dmem_we(n_dmem_we), .dmem_addr(n_dmem_addr),
    .dmem_wdata(n_dmem_wdata), .dmem_ready(n_dmem_req), .dmem_rdata(32'h0),
    .retire(n_retire), .halted(n_halted)
  );

  // Memory model
  logic [31:0] rom  [0:63];
  logic [31:0] dram [0:63];
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;

  assign imem_ready = imem_req && (icnt >= iwait);
  assign imem_rdata = rom[imem_addr[7:2]];
  assign dmem_ready = dmem_req && (dcnt >= dwait);
  assign dmem_rdata = dram[dmem_addr[7:2]];

  always @(posedge clock) begin
    icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ready && dmem_we) dram[dmem_addr[7:2]] <= dmem_wdata;
  end

  // Trace monitor, sampled mid-cycle.
  int          cycles, rets, nfetch, nstore, req_cnt, unstable, n_nf;
  logic        started, mem_busy;
  logic [48:0] held;
  int          ret_cyc [0:63];
  logic [15:0] fetch_log [0:63];
  logic [15:0] st_addr [0:63];
  logic [31:0] st_data [0:63];
  logic [7:0]  n_fetch [0:7];

  always @(negedge clock) begin
    if (reset) begin
      cycles <= 0; rets <= 0; nfetch <= 0; nstore <= 0; req_cnt <= 0;
      unstable <= 0; started <= 1'b0; mem_busy <= 1'b0; n_nf <= 0;
    end else begin
      if (started || imem_req) begin
        started <= 1'b1;
        cycles  <= cycles + 1;
      end
      if (retire && rets < 64) begin
        ret_cyc[rets] <= cycles + 1;
        rets          <= rets + 1;
      end
      if (imem_req && imem_ready && nfetch < 64) begin
        fetch_log[nfetch] <= imem_addr;
        nfetch            <= nfetch + 1;
      end
      if (dmem_req && dmem_ready && dmem_we && nstore < 64) begin
        st_addr[nstore] <= dmem_addr;
        st_data[nstore] <= dmem_wdata;
        nstore          <= nstore + 1;
      end
      if (dmem_req) begin
        if (mem_busy && ({dmem_we, dmem_addr, dmem_wdata} != held)) unstable <= unstable + 1;
        held     <= {dmem_we, dmem_addr, dmem_wdata};
        mem_busy <= !dmem_ready;
      end else begin
        mem_busy <= 1'b0;
      end
      if (imem_req || dmem_req) req_cnt <= req_cnt + 1;
      if (n_imem_req && n_nf < 8) begin
        n_fetch[n_nf] <= n_imem_addr;
        n_nf          <= n_nf + 1;
      end
    end
  end

  int n_checks = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'b0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic clear_rom;
    for (int i = 0; i < 64; i++) rom[i] = 32'hFFFF_FFFF;
  endtask

  // One sampled reset edge, then check the quiet cycle and the first fetch.
  task automatic do_reset;
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    check_eq("rst_ctrl", {27'h0, imem_req, dmem_req, dmem_we, retire, halted}, 32'h0);
    check_eq("rst_addr", {imem_addr, dmem_addr}, 32'h0);
    check_eq("rst_wdata", dmem_wdata, 32'h0);
    check_eq("rst_narrow", {11'h0, n_imem_req, n_dmem_req, n_dmem_we, n_retire, n_halted,
                            n_imem_addr, n_dmem_addr}, 32'h0);
    reset = 1'b0;
    @(posedge clock); #1;
    check_eq("first_fetch", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0000});
  endtask

  task automatic wait_halted(input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    #1;
    check_eq("halt_reached", {31'h0, halted}, 32'h1);
  endtask

  initial begin
    logic [31:0] exp3 [0:6];
    logic [15:0] exp4 [0:9];
    int base_req, base_ret, n;

    // Program 1: zero-wait ALU sequence and HALT behaviour.
    clear_rom();
    rom[0] = enc_i(6'b001000, 5'd0, 5'd1, 16'd5);        // addi r1,r0,5
    rom[1] = enc_i(6'b001000, 5'd0, 5'd2, 16'hFFFD);     // addi r2,r0,-3
    rom[2] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000);   // add r3,r1,r2
    rom[3] = enc_i(6'b101011, 5'd0, 5'd3, 16'h40);       // sw r3,0x40(r0)
    do_reset();
    wait_halted(200);
    check_eq("p1_third_retire_cycle", ret_cyc[2], 32'd12);
    check_eq("p1_retires", rets, 32'd4);
    check_eq("p1_st_addr", {16'h0, st_addr[0]}, 32'h40);
    check_eq("p1_r3", st_data[0], 32'h2);
    base_req = req_cnt;
    base_ret = rets;
    repeat (20) @(negedge clock);
    #1;
    check_eq("halt_no_req", req_cnt - base_req, 32'd0);
    check_eq("halt_no_retire", rets - base_ret, 32'd0);
    check_eq("halt_held", {31'h0, halted}, 32'h1);
    check_eq("n_fetches", n_nf, 32'd2);
    check_eq("n_fetch0", {24'h0, n_fetch[0]}, 32'hFC);
    check_eq("n_wrap_target", {24'h0, n_fetch[1]}, 32'h04);
    check_eq("n_halted", {31'h0, n_halted}, 32'h1);

    // Program 2: store then load with two data wait cycles each.
    clear_rom();
    dwait = 2;
    rom[0] = enc_i(6'b001000, 5'd0, 5'd1, 16'd5);        // addi r1,r0,5
    rom[1] = enc_i(6'b101011, 5'd0, 5'd1, 16'd8);        // sw r1,8(r0)
    rom[2] = enc_i(6'b100011, 5'd0, 5'd4, 16'd8);        // lw r4,8(r0)
    rom[3] = enc_i(6'b101011, 5'd0, 5'd4, 16'h44);       // sw r4,0x44(r0)
    do_reset();
    wait_halted(300);
    check_eq("p2_sw_cycles", ret_cyc[1] - ret_cyc[0], 32'd6);
    check_eq("p2_sw_lw_cycles", ret_cyc[2] - ret_cyc[0], 32'd13);
    check_eq("p2_sw_addr", {16'h0, st_addr[0]}, 32'h8);
    check_eq("p2_sw_data", st_data[0], 32'h5);
    check_eq("p2_mem_stable", unstable, 32'd0);
    check_eq("p2_r4_addr", {16'h0, st_addr[1]}, 32'h44);
    check_eq("p2_r4", st_data[1], 32'h5);
    dwait = 0;

    // Program 3: shifts, compares, lui, ori, sub; one fetch wait cycle.
    clear_rom();
    iwait = 1;
    rom[0]  = enc_i(6'b001111, 5'd0, 5'd5, 16'h8000);    // lui r5,0x8000
    rom[1]  = enc_r(5'd0, 5'd5, 5'd6, 5'd4, 6'b000011);  // sra r6,r5,4
    rom[2]  = enc_i(6'b001010, 5'd5, 5'd7, 16'd1);       // slti r7,r5,1
    rom[3]  = enc_i(6'b001111, 5'd0, 5'd8, 16'h1234);    // lui r8,0x1234
    rom[4]  = enc_r(5'd5, 5'd0, 5'd9, 5'd0, 6'b101010);  // slt r9,r5,r0
    rom[5]  = enc_r(5'd0, 5'd5, 5'd10, 5'd4, 6'b000010); // srl r10,r5,4
    rom[6]  = enc_i(6'b001101, 5'd0, 5'd12, 16'hFFFF);   // ori r12,r0,0xFFFF
    rom[7]  = enc_r(5'd0, 5'd7, 5'd13, 5'd0, 6'b100010); // sub r13,r0,r7
    rom[8]  = enc_i(6'b101011, 5'd0, 5'd6, 16'd0);
    rom[9]  = enc_i(6'b101011, 5'd0, 5'd7, 16'd4);
    rom[10] = enc_i(6'b101011, 5'd0, 5'd8, 16'd8);
    rom[11] = enc_i(6'b101011, 5'd0, 5'd9, 16'd12);
    rom[12] = enc_i(6'b101011, 5'd0, 5'd10, 16'd16);
    rom[13] = enc_i(6'b101011, 5'd0, 5'd12, 16'd20);
    rom[14] = enc_i(6'b101011, 5'd0, 5'd13, 16'd24);
    exp3 = '{32'hF800_0000, 32'h1, 32'h1234_0000, 32'h1, 32'h0800_0000, 32'h0000_FFFF,
             32'hFFFF_FFFF};
    do_reset();
    wait_halted(600);
    check_eq("p3_stores", nstore, 32'd7);
    for (int i = 0; i < 7; i++) check_eq($sformatf("p3_val%0d", i), st_data[i], exp3[i]);
    iwait = 0;

    // Program 4: r0 write, unsupported opcode, j/jal/jr/beq.
    clear_rom();
    rom[0]  = enc_i(6'b001000, 5'd0, 5'd0, 16'd7);       // addi r0,r0,7
    rom[1]  = enc_i(6'b101011, 5'd0, 5'd0, 16'h80);      // sw r0,0x80(r0)
    rom[2]  = enc_i(6'b111000, 5'd0, 5'd20, 16'h1234);   // unsupported
    rom[3]  = enc_j(6'b000010, 26'h8);                   // j 0x20
    rom[8]  = enc_j(6'b000011, 26'h10);                  // jal 0x40
    rom[16] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'b001000); // jr r31
    rom[9]  = enc_i(6'b101011, 5'd0, 5'd31, 16'h84);     // sw r31,0x84(r0)
    rom[10] = enc_i(6'b000100, 5'd0, 5'd0, 16'd1);       // beq r0,r0,+1
    rom[11] = enc_i(6'b001000, 5'd0, 5'd20, 16'd1);      // addi r20,r0,1 (skipped)
    rom[12] = enc_i(6'b101011, 5'd0, 5'd20, 16'h88);     // sw r20,0x88(r0)
    exp4 = '{16'h00, 16'h04, 16'h08, 16'h0C, 16'h20, 16'h40, 16'h24, 16'h28, 16'h30, 16'h34};
    do_reset();
    wait_halted(300);
    check_eq("p4_fetches", nfetch, 32'd10);
    for (int i = 0; i < 10; i++)
      check_eq($sformatf("p4_pc%0d", i), {16'h0, fetch_log[i]}, {16'h0, exp4[i]});
    check_eq("p4_retires", rets, 32'd9);
    check_eq("p4_unsup_cycles", ret_cyc[2] - ret_cyc[1], 32'd3);
    check_eq("p4_r0", st_data[0], 32'h0);
    check_eq("p4_link", st_data[1], 32'h24);
    check_eq("p4_r20", st_data[2], 32'h0);

    // Program 5: bne with offset -1 spins on itself.
    clear_rom();
    rom[0] = enc_i(6'b001000, 5'd0, 5'd1, 16'd1);        // addi r1,r0,1
    rom[1] = enc_j(6'b000010, 26'h4);                    // j 0x10
    rom[4] = enc_i(6'b000101, 5'd1, 5'd0, 16'hFFFF);     // bne r1,r0,-1
    do_reset();
    n = 0;
    while (nfetch < 6 && n < 200) begin
      @(negedge clock);
      n++;
    end
    #1;
    check_eq("p5_fetches", {31'h0, nfetch >= 6}, 32'h1);
    check_eq("p5_pc2", {16'h0, fetch_log[2]}, 32'h10);
    check_eq("p5_pc5", {16'h0, fetch_log[5]}, 32'h10);

    // Program 6: reset while a store is waiting on dmem_ready.
    clear_rom();
    dwait = 1000;
    rom[0] = enc_i(6'b001000, 5'd0, 5'd1, 16'd9);        // addi r1,r0,9
    rom[1] = enc_i(6'b101011, 5'd0, 5'd1, 16'h50);       // sw r1,0x50(r0)
    do_reset();
    n = 0;
    while (dmem_req !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_eq("p6_in_mem", {31'h0, dmem_req}, 32'h1);
    repeat (2) @(negedge clock);
    do_reset();
    dwait = 0;
    wait_halted(200);
    check_eq("p6_restart_pc", {16'h0, fetch_log[0]}, 32'h0);
    check_eq("p6_fetches", nfetch, 32'd3);
    check_eq("p6_stores", nstore, 32'd1);
    check_eq("p6_st_data", st_data[0], 32'h9);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
